// File: rtl/hssi_mac_fiu_if_pkg.sv
// Shared types for the HSSI MAC/FIU interface.
// Holds the transceiver reset sequencer state encoding and output decode.
package hssi_mac_fiu_if_pkg;

    localparam int HSSI_SEQ_CNT_W_DEFAULT = 24;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_TX_ANA,
        SEQ_TX_PLL,
        SEQ_TX_DIG,
        SEQ_RX_ANA,
        SEQ_RX_CDR,
        SEQ_RX_DIG,
        SEQ_READY
    } t_hssi_xcvr_seq_state;

    typedef struct packed {
        logic tx_ana;
        logic tx_dig;
        logic rx_ana;
        logic rx_dig;
        logic l2r;
        logic l2d;
        logic tx_rdy;
        logic rx_rdy;
    } t_hssi_seq_ctl;

    // States are ordered by bring-up progress, so each control is a threshold.
    function automatic t_hssi_seq_ctl hssi_seq_decode(
        input t_hssi_xcvr_seq_state s
    );
        t_hssi_seq_ctl c;
        c.tx_ana = (s <= SEQ_TX_ANA);
        c.tx_dig = (s <= SEQ_TX_PLL);
        c.rx_ana = (s <= SEQ_RX_ANA);
        c.rx_dig = (s <= SEQ_RX_CDR);
        c.l2r    = (s <= SEQ_RX_ANA);
        c.l2d    = 1'b0;
        c.tx_rdy = (s >= SEQ_RX_ANA);
        c.rx_rdy = (s == SEQ_READY);
        return c;
    endfunction

endpackage

// File: rtl/hssi_stable_cnt.sv
// Qualify/clear saturating counter with a terminal-count flag.
module hssi_stable_cnt
    import hssi_mac_fiu_if_pkg::*;
#(
    parameter int CNT_W = HSSI_SEQ_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             qual_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !qual_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q >= term_i);

endmodule

// File: rtl/hssi_xcvr_reset_seq.sv
// Per-port transceiver reset and lock sequencer (TX first, then RX).
// Recovers from PLL/CDR lock loss and lock timeout with a retry count.
module hssi_xcvr_reset_seq
    import hssi_mac_fiu_if_pkg::*;
#(
    parameter int NUM_LN           = 4,
    parameter int CNT_W            = HSSI_SEQ_CNT_W_DEFAULT,
    parameter int TX_ANALOG_CYC    = 64,
    parameter int RX_ANALOG_CYC    = 64,
    parameter int PLL_STABLE_CYC   = 256,
    parameter int CDR_STABLE_CYC   = 1024,
    parameter int LOCK_TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init_start,
    input  logic              tx_cal_busy,
    input  logic              tx_pll_locked,
    input  logic              rx_cal_busy,
    input  logic [NUM_LN-1:0] rx_is_lockedtodata,
    output logic [NUM_LN-1:0] tx_analogreset,
    output logic [NUM_LN-1:0] tx_digitalreset,
    output logic [NUM_LN-1:0] rx_analogreset,
    output logic [NUM_LN-1:0] rx_digitalreset,
    output logic [NUM_LN-1:0] rx_set_locktoref,
    output logic [NUM_LN-1:0] rx_set_locktodata,
    output logic              tx_ready,
    output logic              rx_ready,
    output logic              init_done,
    output logic [7:0]        retry_cnt
);

    localparam longint CNT_LIM = longint'(1) << CNT_W;

    if (longint'(TX_ANALOG_CYC) >= CNT_LIM ||
        longint'(RX_ANALOG_CYC) >= CNT_LIM ||
        longint'(PLL_STABLE_CYC) >= CNT_LIM ||
        longint'(CDR_STABLE_CYC) >= CNT_LIM ||
        longint'(LOCK_TIMEOUT_CYC) >= CNT_LIM) begin : g_bad_param
        $error("hssi_xcvr_reset_seq: cycle parameter exceeds CNT_W");
    end

    localparam logic [CNT_W-1:0] T_TXA = CNT_W'(TX_ANALOG_CYC);
    localparam logic [CNT_W-1:0] T_RXA = CNT_W'(RX_ANALOG_CYC);
    localparam logic [CNT_W-1:0] T_PLL = CNT_W'(PLL_STABLE_CYC);
    localparam logic [CNT_W-1:0] T_CDR = CNT_W'(CDR_STABLE_CYC);
    localparam logic [CNT_W-1:0] T_TO  = CNT_W'(LOCK_TIMEOUT_CYC);

    t_hssi_xcvr_seq_state state_q;
    t_hssi_xcvr_seq_state state_d;
    t_hssi_seq_ctl        ctl_q;
    logic [7:0]           retry_q;
    logic [7:0]           retry_d;
    logic                 retry_inc;

    logic             dly_qual;
    logic [CNT_W-1:0] dly_term;
    logic             dly_tc;
    logic             to_qual;
    logic             to_tc;
    logic             cnt_clr;
    logic             pll_lost;
    logic             cdr_lost;

    assign pll_lost = !tx_pll_locked;
    assign cdr_lost = !(&rx_is_lockedtodata);
    assign cnt_clr  = (state_d != state_q);
    assign to_qual  = (state_q == SEQ_TX_PLL) || (state_q == SEQ_RX_CDR);

    always_comb begin
        dly_qual = 1'b0;
        dly_term = '1;
        unique case (state_q)
            SEQ_TX_ANA: begin
                dly_qual = !tx_cal_busy;
                dly_term = T_TXA;
            end
            SEQ_TX_PLL: begin
                dly_qual = tx_pll_locked;
                dly_term = T_PLL;
            end
            SEQ_RX_ANA: begin
                dly_qual = !rx_cal_busy;
                dly_term = T_RXA;
            end
            SEQ_RX_CDR: begin
                dly_qual = !cdr_lost;
                dly_term = T_CDR;
            end
            default: ;
        endcase
    end

    hssi_stable_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (cnt_clr),
        .qual_i  (dly_qual),
        .term_i  (dly_term),
        .tc_o    (dly_tc)
    );

    hssi_stable_cnt #(.CNT_W(CNT_W)) u_to_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (cnt_clr),
        .qual_i  (to_qual),
        .term_i  (T_TO),
        .tc_o    (to_tc)
    );

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        if (!init_start) begin
            state_d = SEQ_IDLE;
        end else begin
            unique case (state_q)
                SEQ_IDLE: state_d = SEQ_TX_ANA;
                SEQ_TX_ANA: begin
                    if (dly_tc) state_d = SEQ_TX_PLL;
                end
                SEQ_TX_PLL: begin
                    if (dly_tc) begin
                        state_d = SEQ_TX_DIG;
                    end else if (to_tc) begin
                        state_d   = SEQ_TX_ANA;
                        retry_inc = 1'b1;
                    end
                end
                default: begin
                    // Everything past TX_PLL: PLL loss restarts the whole port.
                    if (pll_lost) begin
                        state_d   = SEQ_TX_ANA;
                        retry_inc = 1'b1;
                    end else begin
                        unique case (state_q)
                            SEQ_TX_DIG: state_d = SEQ_RX_ANA;
                            SEQ_RX_ANA: begin
                                if (dly_tc) state_d = SEQ_RX_CDR;
                            end
                            SEQ_RX_CDR: begin
                                if (dly_tc) begin
                                    state_d = SEQ_RX_DIG;
                                end else if (to_tc) begin
                                    state_d   = SEQ_RX_ANA;
                                    retry_inc = 1'b1;
                                end
                            end
                            default: begin
                                if (cdr_lost) begin
                                    state_d   = SEQ_RX_ANA;
                                    retry_inc = 1'b1;
                                end else begin
                                    state_d = SEQ_READY;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        retry_d = retry_q;
        if (retry_inc && (retry_q != 8'hFF)) begin
            retry_d = retry_q + 8'd1;
        end
    end

    // Controls are decoded from the next state so they move with the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SEQ_IDLE;
            ctl_q   <= hssi_seq_decode(SEQ_IDLE);
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= hssi_seq_decode(state_d);
            retry_q <= retry_d;
        end
    end

    assign tx_analogreset    = {NUM_LN{ctl_q.tx_ana}};
    assign tx_digitalreset   = {NUM_LN{ctl_q.tx_dig}};
    assign rx_analogreset    = {NUM_LN{ctl_q.rx_ana}};
    assign rx_digitalreset   = {NUM_LN{ctl_q.rx_dig}};
    assign rx_set_locktoref  = {NUM_LN{ctl_q.l2r}};
    assign rx_set_locktodata = {NUM_LN{ctl_q.l2d}};
    assign tx_ready          = ctl_q.tx_rdy;
    assign rx_ready          = ctl_q.rx_rdy;
    assign init_done         = ctl_q.rx_rdy;
    assign retry_cnt         = retry_q;

endmodule

// File: tb/tb_hssi_xcvr_reset_seq.sv
// Directed bench for hssi_xcvr_reset_seq with short delay parameters.
// Edge 0 is the first clock edge that samples init_start=1 in IDLE.
module tb_hssi_xcvr_reset_seq;

    logic       clk;
    logic       reset_n;
    logic       init_start;
    logic       tx_cal_busy;
    logic       tx_pll_locked;
    logic       rx_cal_busy;
    logic [3:0] rx_is_lockedtodata;
    logic [3:0] tx_analogreset;
    logic [3:0] tx_digitalreset;
    logic [3:0] rx_analogreset;
    logic [3:0] rx_digitalreset;
    logic [3:0] rx_set_locktoref;
    logic [3:0] rx_set_locktodata;
    logic       tx_ready;
    logic       rx_ready;
    logic       init_done;
    logic [7:0] retry_cnt;

    int n_chk;
    int n_err;
    int e;

    hssi_xcvr_reset_seq #(
        .NUM_LN           (4),
        .CNT_W            (24),
        .TX_ANALOG_CYC    (4),
        .RX_ANALOG_CYC    (4),
        .PLL_STABLE_CYC   (8),
        .CDR_STABLE_CYC   (16),
        .LOCK_TIMEOUT_CYC (100)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .init_start         (init_start),
        .tx_cal_busy        (tx_cal_busy),
        .tx_pll_locked      (tx_pll_locked),
        .rx_cal_busy        (rx_cal_busy),
        .rx_is_lockedtodata (rx_is_lockedtodata),
        .tx_analogreset     (tx_analogreset),
        .tx_digitalreset    (tx_digitalreset),
        .rx_analogreset     (rx_analogreset),
        .rx_digitalreset    (rx_digitalreset),
        .rx_set_locktoref   (rx_set_locktoref),
        .rx_set_locktodata  (rx_set_locktodata),
        .tx_ready           (tx_ready),
        .rx_ready           (rx_ready),
        .init_done          (init_done),
        .retry_cnt          (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, e, got, exp);
        end
    endtask

    task automatic step_to(input int k);
        while (e < k) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    task automatic restart(input logic pll, input logic tcb);
        reset_n            = 1'b0;
        init_start         = 1'b0;
        tx_cal_busy        = tcb;
        tx_pll_locked      = pll;
        rx_cal_busy        = 1'b0;
        rx_is_lockedtodata = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        init_start = 1'b1;
        e = -1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        e     = 0;

        // Reset values, with inputs that would otherwise advance the FSM.
        reset_n            = 1'b0;
        init_start         = 1'b1;
        tx_cal_busy        = 1'b0;
        tx_pll_locked      = 1'b1;
        rx_cal_busy        = 1'b0;
        rx_is_lockedtodata = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_ana", 32'(tx_analogreset), 32'hF);
        chk("rst_tx_dig", 32'(tx_digitalreset), 32'hF);
        chk("rst_rx_ana", 32'(rx_analogreset), 32'hF);
        chk("rst_rx_dig", 32'(rx_digitalreset), 32'hF);
        chk("rst_l2r", 32'(rx_set_locktoref), 32'hF);
        chk("rst_l2d", 32'(rx_set_locktodata), 32'h0);
        chk("rst_rdy", {29'd0, tx_ready, rx_ready, init_done}, 32'h0);
        chk("rst_retry", 32'(retry_cnt), 32'h0);

        // Clean bring-up.
        restart(1'b1, 1'b0);
        step_to(0);
        chk("up_tx_ana_e0", 32'(tx_analogreset), 32'hF);
        step_to(4);
        chk("up_tx_ana_e4", 32'(tx_analogreset), 32'hF);
        step_to(5);
        chk("up_tx_ana_e5", 32'(tx_analogreset), 32'h0);
        chk("up_tx_dig_e5", 32'(tx_digitalreset), 32'hF);
        step_to(13);
        chk("up_tx_dig_e13", 32'(tx_digitalreset), 32'hF);
        step_to(14);
        chk("up_tx_dig_e14", 32'(tx_digitalreset), 32'h0);
        chk("up_tx_rdy_e14", 32'(tx_ready), 32'h0);
        step_to(15);
        chk("up_tx_rdy_e15", 32'(tx_ready), 32'h1);
        chk("up_rx_ana_e15", 32'(rx_analogreset), 32'hF);
        step_to(19);
        chk("up_l2r_e19", 32'(rx_set_locktoref), 32'hF);
        step_to(20);
        chk("up_rx_ana_e20", 32'(rx_analogreset), 32'h0);
        chk("up_l2r_e20", 32'(rx_set_locktoref), 32'h0);
        chk("up_l2d_e20", 32'(rx_set_locktodata), 32'h0);
        step_to(36);
        chk("up_rx_dig_e36", 32'(rx_digitalreset), 32'hF);
        step_to(37);
        chk("up_rx_dig_e37", 32'(rx_digitalreset), 32'h0);
        chk("up_rx_rdy_e37", 32'(rx_ready), 32'h0);
        step_to(38);
        chk("up_rx_rdy_e38", 32'(rx_ready), 32'h1);
        chk("up_done_e38", 32'(init_done), 32'h1);
        chk("up_retry", 32'(retry_cnt), 32'h0);

        // Lane 0 CDR loss in READY: RX restarts, TX untouched.
        step_to(40);
        rx_is_lockedtodata = 4'hE;
        step_to(41);
        chk("cdrloss_rx_rdy", 32'(rx_ready), 32'h0);
        chk("cdrloss_rx_ana", 32'(rx_analogreset), 32'hF);
        chk("cdrloss_tx_rdy", 32'(tx_ready), 32'h1);
        chk("cdrloss_tx_ana", 32'(tx_analogreset), 32'h0);
        chk("cdrloss_retry", 32'(retry_cnt), 32'h1);
        rx_is_lockedtodata = 4'hF;
        step_to(63);
        chk("relock_rx_rdy_e63", 32'(rx_ready), 32'h0);
        step_to(64);
        chk("relock_rx_rdy_e64", 32'(rx_ready), 32'h1);

        // Simultaneous PLL and CDR loss: PLL loss wins.
        step_to(66);
        tx_pll_locked      = 1'b0;
        rx_is_lockedtodata = 4'h0;
        step_to(67);
        chk("pllloss_tx_rdy", 32'(tx_ready), 32'h0);
        chk("pllloss_rx_rdy", 32'(rx_ready), 32'h0);
        chk("pllloss_tx_ana", 32'(tx_analogreset), 32'hF);
        chk("pllloss_tx_dig", 32'(tx_digitalreset), 32'hF);
        chk("pllloss_rx_ana", 32'(rx_analogreset), 32'hF);
        chk("pllloss_retry", 32'(retry_cnt), 32'h2);
        tx_pll_locked      = 1'b1;
        rx_is_lockedtodata = 4'hF;

        // Reset asserted while in RX_CDR (entered at edge 87).
        step_to(90);
        chk("mid_in_cdr", 32'(rx_analogreset), 32'h0);
        reset_n = 1'b0;
        step_to(91);
        chk("mid_tx_ana", 32'(tx_analogreset), 32'hF);
        chk("mid_tx_dig", 32'(tx_digitalreset), 32'hF);
        chk("mid_rx_ana", 32'(rx_analogreset), 32'hF);
        chk("mid_rx_dig", 32'(rx_digitalreset), 32'hF);
        chk("mid_retry", 32'(retry_cnt), 32'h0);
        chk("mid_tx_rdy", 32'(tx_ready), 32'h0);

        // init_start low in TX_PLL returns to IDLE next edge.
        restart(1'b1, 1'b0);
        step_to(10);
        chk("stop_in_pll", 32'(tx_analogreset), 32'h0);
        init_start = 1'b0;
        step_to(11);
        chk("stop_tx_ana", 32'(tx_analogreset), 32'hF);
        chk("stop_l2r", 32'(rx_set_locktoref), 32'hF);
        step_to(20);
        chk("stop_hold_idle", 32'(tx_analogreset), 32'hF);

        // TX calibration busy through edge 19.
        restart(1'b1, 1'b1);
        step_to(19);
        chk("cal_e19", 32'(tx_analogreset), 32'hF);
        tx_cal_busy = 1'b0;
        step_to(23);
        chk("cal_e23", 32'(tx_analogreset), 32'hF);
        step_to(24);
        chk("cal_e24", 32'(tx_analogreset), 32'h0);

        // PLL never locks: timeout after 101 cycles in TX_PLL (entered at 5).
        restart(1'b0, 1'b0);
        step_to(105);
        chk("to_tx_ana_e105", 32'(tx_analogreset), 32'h0);
        chk("to_retry_e105", 32'(retry_cnt), 32'h0);
        step_to(106);
        chk("to_tx_ana_e106", 32'(tx_analogreset), 32'hF);
        chk("to_tx_dig_e106", 32'(tx_digitalreset), 32'hF);
        chk("to_retry_e106", 32'(retry_cnt), 32'h1);

        // One-cycle lane 2 glitch at CDR stable count 10 delays READY by 11.
        restart(1'b1, 1'b0);
        step_to(30);
        rx_is_lockedtodata = 4'hB;
        step_to(31);
        rx_is_lockedtodata = 4'hF;
        step_to(38);
        chk("glitch_e38", 32'(rx_ready), 32'h0);
        step_to(48);
        chk("glitch_e48", 32'(rx_ready), 32'h0);
        step_to(49);
        chk("glitch_e49", 32'(rx_ready), 32'h1);
        chk("glitch_retry", 32'(retry_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
